led_pixel_assembler: RTL
========================

Name: led_pixel_assembler

Overview:
Final stage of the LED data-in pipeline. Consumes the decoded-bit stream from the decoder stage 2 output as a shift_reg_input_t: decode_bit, valid_strobe, treset. Assembles MSB-first GRB words, emits each completed pixel with its index, and reports frame boundaries and framing errors. On each treset it commits the frame's first pixel to a display register, which is the single-LED latch behaviour.

Parameters:
BITS_PER_PIXEL, 24, bits per pixel word (GRB 8:8:8), legal range 2..32
MAX_PIXELS, 256, pixels counted per frame; sets index width
IDX_W, $clog2(MAX_PIXELS), width of the pixel index and count outputs (derived)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
shift_in  input  3  pipeline_types::shift_reg_input_t {decode_bit, valid_strobe, treset}
pixel_data  output  BITS_PER_PIXEL  last completed pixel word, MSB = first bit received
pixel_valid  output  1  one-cycle strobe: pixel_data and pixel_index are new
pixel_index  output  IDX_W  position of pixel_data in the current frame, 0-based
display_rgb  output  BITS_PER_PIXEL  committed first pixel of the last good frame
frame_done  output  1  one-cycle strobe on every accepted treset
frame_count  output  IDX_W  number of complete pixels in the frame just ended, valid with frame_done
frame_error  output  1  one-cycle strobe with frame_done when the frame ended mid-pixel
overflow  output  1  sticky flag: more than MAX_PIXELS pixels in the frame; cleared by treset

Behaviour:
- One clock and one reset. Reset is asynchronous and active-low (rst_n). All registers clear on reset.
- Reset values: every output is 0, shift register is 0, bit_cnt is 0, pix_cnt is 0, first_pix is 0, FSM is in IDLE.
- FSM has three states:
  - IDLE: no bit seen since reset or the last treset.
  - RX: at least one bit seen.
  - OVF: the pixel count has exceeded MAX_PIXELS.
- FSM transitions:
  - IDLE goes to RX on valid_strobe.
  - RX goes to OVF when a pixel completes while pix_cnt = MAX_PIXELS-1.
  - Any state goes to IDLE on treset.
- Bit capture: on valid_strobe (with no treset), sr <= {sr[BITS_PER_PIXEL-2:0], decode_bit} and bit_cnt increments.
- Pixel completion: a pixel completes on a strobe with bit_cnt = BITS_PER_PIXEL-1. On the next cycle:
  - pixel_data is the complete word, including the final bit.
  - pixel_valid = 1 and pixel_index = pix_cnt.
  - bit_cnt wraps to 0.
  - pix_cnt increments.
- Completion latency is exactly 1 cycle from the final strobe.
- If pix_cnt = 0 at completion, the word is also stored in first_pix.
- OVF state:
  - Bits are still shifted and words still emitted with pixel_valid.
  - pixel_index holds at MAX_PIXELS-1 and pix_cnt saturates.
  - overflow = 1 and stays high until treset.
- treset handling (a pulse; back-to-back tresets are each handled). The cycle after treset:
  - frame_done = 1 and frame_count = pix_cnt (saturated).
  - frame_error = 1 iff bit_cnt != 0.
  - bit_cnt, pix_cnt and overflow clear, and the FSM enters IDLE.
  - The partial shift-register content is discarded.
- display_rgb update on treset:
  - Loads first_pix iff pix_cnt >= 1 and there is no frame error.
  - Otherwise it holds its previous value.
  - A treset in IDLE produces frame_done with frame_count = 0 and frame_error = 0. display_rgb is unchanged.
- Simultaneous valid_strobe and treset in the same cycle: treset has priority. The bit is discarded and no pixel_valid is generated, even if it would have completed a pixel.
- pixel_valid and frame_done are never asserted in the same cycle, because of treset priority.
- pixel_data and pixel_index hold their values between strobes.
- Reset mid-frame clears everything immediately (asynchronous). There is no frame_done for the aborted frame.

Test Plan:
- Reset: assert rst_n = 0 mid-pixel, with 10 bits shifted -> all outputs 0; after release, 24 strobes of pattern 0xA5C3F0 yield pixel_valid once with pixel_data = 0xA5C3F0 and pixel_index = 0.
- Two pixels then treset: shift 0x112233 then 0x445566, then treset -> pixel_valid pulses with index 0 then 1; frame_done = 1, frame_count = 2, frame_error = 0; display_rgb = 0x112233 on the cycle after frame_done.
- Partial frame: shift 0x00FF00, then 5 more bits, then treset -> frame_done = 1, frame_count = 1, frame_error = 1; display_rgb keeps its previous value; the next frame starts at pixel_index 0.
- Collision: assert valid_strobe and treset together on the 24th bit -> no pixel_valid; frame_done = 1, frame_count = 0, frame_error = 1.
- Overflow (MAX_PIXELS = 4): shift 6 pixels -> pixel_index sequence 0,1,2,3,3,3; overflow rises with the 5th pixel_valid; treset gives frame_count = 3 and clears overflow.
- Idle treset and strobe gaps: treset with no bits -> frame_done = 1, frame_count = 0, frame_error = 0, display_rgb unchanged; strobes spaced 1 to 50 cycles apart assemble identically to back-to-back strobes.

Source files
------------

// File: rtl/led_pixel_assembler.sv
// rtl/led_pixel_assembler.sv - MSB-first pixel word assembler with frame tracking and display latch
//
// Purpose: shifts decoded bits into BITS_PER_PIXEL-wide words, emits each
// completed word with its index in the frame, reports frame boundaries and
// framing errors on treset, and latches the first pixel of every clean frame
// into display_rgb (single-LED latch behaviour).
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   shift_in     {decode_bit, valid_strobe, treset} from the decoder stage
//   pixel_data   last completed pixel word, MSB = first bit received
//   pixel_valid  one-cycle strobe, pixel_data/pixel_index are new
//   pixel_index  0-based position of pixel_data in the frame (saturating)
//   display_rgb  first pixel of the last frame that ended cleanly
//   frame_done   one-cycle strobe on every accepted treset
//   frame_count  complete pixels in the frame just ended (saturating)
//   frame_error  one-cycle strobe with frame_done when the frame ended mid-pixel
//   overflow     sticky, more than MAX_PIXELS pixels seen; cleared by treset
module led_pixel_assembler #(
  parameter int BITS_PER_PIXEL = 24,
  parameter int MAX_PIXELS     = 256,
  parameter int IDX_W          = $clog2(MAX_PIXELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [2:0]                shift_in,
  output logic [BITS_PER_PIXEL-1:0] pixel_data,
  output logic                      pixel_valid,
  output logic [IDX_W-1:0]          pixel_index,
  output logic [BITS_PER_PIXEL-1:0] display_rgb,
  output logic                      frame_done,
  output logic [IDX_W-1:0]          frame_count,
  output logic                      frame_error,
  output logic                      overflow
);

  localparam int                BC_W     = $clog2(BITS_PER_PIXEL);
  localparam logic [BC_W-1:0]   LAST_BIT = BC_W'(BITS_PER_PIXEL - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(MAX_PIXELS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RX,
    S_OVF
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [BITS_PER_PIXEL-1:0] r_sr;
  logic [BC_W-1:0]           r_bit_cnt;
  logic [IDX_W-1:0]          r_pix_cnt;
  logic [BITS_PER_PIXEL-1:0] r_first_pix;
  logic [BITS_PER_PIXEL-1:0] r_pixel_data;
  logic                      r_pixel_valid;
  logic [IDX_W-1:0]          r_pixel_index;
  logic [BITS_PER_PIXEL-1:0] r_display_rgb;
  logic                      r_frame_done;
  logic [IDX_W-1:0]          r_frame_count;
  logic                      r_frame_error;
  logic                      r_overflow;

  logic                      w_decode_bit;
  logic                      w_treset;
  logic                      w_strobe;
  logic                      w_complete;
  logic [BITS_PER_PIXEL-1:0] w_sr_next;

  assign w_decode_bit = shift_in[2];
  assign w_treset     = shift_in[0];
  // treset wins over a coincident strobe: that bit is dropped entirely
  assign w_strobe     = shift_in[1] & ~shift_in[0];
  assign w_complete   = w_strobe && (r_bit_cnt == LAST_BIT);
  assign w_sr_next    = {r_sr[BITS_PER_PIXEL-2:0], w_decode_bit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_strobe) w_state_nxt = S_RX;
      S_RX:    if (w_complete && (r_pix_cnt == LAST_IDX)) w_state_nxt = S_OVF;
      S_OVF:   w_state_nxt = S_OVF;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_treset) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr          <= '0;
      r_bit_cnt     <= '0;
      r_pix_cnt     <= '0;
      r_first_pix   <= '0;
      r_pixel_data  <= '0;
      r_pixel_valid <= 1'b0;
      r_pixel_index <= '0;
      r_display_rgb <= '0;
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
      r_frame_error <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_pixel_valid <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_error <= 1'b0;
      if (w_treset) begin
        r_frame_done  <= 1'b1;
        r_frame_count <= r_pix_cnt;
        r_frame_error <= (r_bit_cnt != '0);
        // first_pix belongs to this frame whenever pix_cnt is non-zero
        if ((r_pix_cnt != '0) && (r_bit_cnt == '0)) r_display_rgb <= r_first_pix;
        r_sr          <= '0;
        r_bit_cnt     <= '0;
        r_pix_cnt     <= '0;
        r_overflow    <= 1'b0;
      end else if (w_strobe) begin
        r_sr <= w_sr_next;
        if (w_complete) begin
          r_bit_cnt     <= '0;
          r_pixel_valid <= 1'b1;
          r_pixel_data  <= w_sr_next;
          r_pixel_index <= r_pix_cnt;
          if (r_pix_cnt == '0) r_first_pix <= w_sr_next;
          // pix_cnt saturates at MAX_PIXELS-1; pixels beyond that land in OVF
          if (r_pix_cnt != LAST_IDX) r_pix_cnt <= r_pix_cnt + 1'b1;
          if (r_state == S_OVF) r_overflow <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end
    end
  end

  assign pixel_data  = r_pixel_data;
  assign pixel_valid = r_pixel_valid;
  assign pixel_index = r_pixel_index;
  assign display_rgb = r_display_rgb;
  assign frame_done  = r_frame_done;
  assign frame_count = r_frame_count;
  assign frame_error = r_frame_error;
  assign overflow    = r_overflow;

endmodule
